// File: rtl/clock_pulse_scheduler_pkg.sv
// clock_sched_pkg: scheduler state encoding, default widths and the divisor clamp
package clock_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam int DIV_W_DEF = 16;
  localparam int BURST_W_DEF = 16;
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction
endpackage

// File: rtl/clock_pulse_scheduler_if.sv
// clock_pulse_scheduler_if: valid/ready configuration port carrying divisor and burst length
interface clock_pulse_scheduler_if
  import clock_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) ();
  logic cfg_valid;
  logic cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  modport master (output cfg_valid, cfg_div, cfg_burst, input cfg_ready);
  modport slave (input cfg_valid, cfg_div, cfg_burst, output cfg_ready);
endinterface

// File: rtl/clock_pulse_scheduler_div_core.sv
// clock_div_core: half-period counter with terminal count and registered clk_out/tick
module clock_div_core #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tc,
  output logic             o_clk_out,
  output logic             o_tick
);
  logic [DIV_W-1:0] r_cnt;
  logic r_clk_out, r_tick;
  assign o_tc = r_cnt == i_div - DIV_W'(1);
  assign o_clk_out = r_clk_out;
  assign o_tick = r_tick;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      r_clk_out <= 1'b0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + DIV_W'(1);
      r_clk_out <= r_clk_out ^ o_tc;
      r_tick <= o_tc && !r_clk_out;
    end else begin
      r_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/clock_pulse_scheduler.sv
// clock_pulse_scheduler: start/stop/burst sequencing and live reconfiguration of a clock divider
module clock_pulse_scheduler
  import clock_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 2500,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic clk_in,
  input  logic rst,
  input  logic start,
  input  logic stop,
  clock_pulse_scheduler_if.slave cfg,
  output logic clk_out,
  output logic tick,
  output logic busy,
  output logic done
);
  state_t r_state, w_nxt;
  logic [DIV_W-1:0] r_div, r_sh_div, w_new_div;
  logic [BURST_W-1:0] r_burst, r_sh_burst, r_edges;
  logic r_pend, r_cfg_ready, r_busy, r_done;
  logic w_tc_raw, w_run, w_stop_lo, w_en, w_tc, w_rise, w_fall, w_burst_end;
  logic w_accept, w_apply, w_shadow, w_pend_nxt, w_clr;
  assign w_new_div = DIV_W'(clamp_div(32'(cfg.cfg_div)));
  assign cfg.cfg_ready = r_cfg_ready;
  assign busy = r_busy;
  assign done = r_done;
  always_comb begin
    w_run = r_state == RUN;
    w_stop_lo = w_run && stop && !clk_out;
    w_en = (w_run && !w_stop_lo) || r_state == STOPPING;
    w_clr = r_state == IDLE || w_stop_lo;
    w_tc = w_en && w_tc_raw;
    w_rise = w_tc && !clk_out;
    w_fall = w_tc && clk_out;
    w_burst_end = w_rise && r_burst != '0 && r_edges + BURST_W'(1) == r_burst;
    w_accept = cfg.cfg_valid && r_cfg_ready;
    w_shadow = w_accept && r_state != IDLE;
    w_apply = r_pend && (w_tc || r_state == IDLE);
    w_pend_nxt = w_shadow || (r_pend && !w_apply);
    w_nxt = r_state == IDLE ? ((start && !stop) ? RUN : IDLE) :
            r_state == RUN  ? ((w_stop_lo || (stop && w_fall)) ? IDLE :
                               (stop || w_burst_end) ? STOPPING : RUN) :
            (w_fall ? IDLE : STOPPING);
  end
  // a stop in the high phase waits for the falling TC so clk_out never glitches
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state <= IDLE;
      r_div <= DIV_W'(DEFAULT_DIV);
      r_burst <= '0;
      r_sh_div <= '0;
      r_sh_burst <= '0;
      r_edges <= '0;
      r_pend <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy <= w_nxt != IDLE;
      r_done <= w_nxt == IDLE && r_state != IDLE;
      r_edges <= r_state == IDLE ? '0 :
                 (w_rise && (r_burst == '0 || r_edges != r_burst)) ? r_edges + BURST_W'(1) : r_edges;
      r_pend <= w_pend_nxt;
      r_cfg_ready <= !w_pend_nxt;
      if (w_apply) begin
        r_div <= r_sh_div;
        r_burst <= r_sh_burst;
      end
      if (w_accept && r_state == IDLE) begin
        r_div <= w_new_div;
        r_burst <= cfg.cfg_burst;
      end
      if (w_shadow) begin
        r_sh_div <= w_new_div;
        r_sh_burst <= cfg.cfg_burst;
      end
    end
  end
  clock_div_core #(.DIV_W(DIV_W)) u_core (
    .clk(clk_in),
    .rst(rst),
    .i_clr(w_clr),
    .i_en(w_en),
    .i_div(r_div),
    .o_tc(w_tc_raw),
    .o_clk_out(clk_out),
    .o_tick(tick)
  );
endmodule

// File: tb/tb_clock_pulse_scheduler.sv
// tb_clock_pulse_scheduler: directed vectors with hand-computed expectations, DEFAULT_DIV=4
module tb_clock_pulse_scheduler;
  logic clk = 1'b0;
  logic rst, start, stop, clk_out, tick, busy, done;
  int checks = 0;
  int errors = 0;
  int n, d;
  clock_pulse_scheduler_if cif ();
  clock_pulse_scheduler #(.DIV_W(16), .DEFAULT_DIV(4), .BURST_W(16)) dut (
    .clk_in(clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .cfg(cif),
    .clk_out(clk_out),
    .tick(tick),
    .busy(busy),
    .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input int cnt = 1);
    repeat (cnt) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic cfg_write(input int dv, input int bv);
    cif.cfg_valid = 1'b1;
    cif.cfg_div = 16'(dv);
    cif.cfg_burst = 16'(bv);
    step();
    cif.cfg_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic run_until_done(input int max, output int ticks, output int at);
    ticks = 0;
    at = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      ticks += int'(tick);
      if (done) begin
        at = i;
        break;
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_div = '0; cif.cfg_burst = '0;
    step(3);
    rst = 1'b0;
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cif.cfg_ready, 1);
    go();
    chk("start_busy", busy, 1);
    step(3);
    chk("pre_rise", clk_out, 0);
    step();
    chk("rise_clk", clk_out, 1);
    chk("rise_tick", tick, 1);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      n += int'(tick);
    end
    chk("period_ticks", n, 2);
    chk("tick_period8", tick, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_hi_busy", busy, 1);
    step(2);
    chk("stop_hi_hold", clk_out, 1);
    step();
    chk("stop_hi_fall", clk_out, 0);
    chk("stop_hi_done", done, 1);
    chk("stop_hi_busy_low", busy, 0);
    step();
    chk("stop_hi_done_once", done, 0);
    go();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_lo_done", done, 1);
    chk("stop_lo_busy", busy, 0);
    chk("stop_lo_clk", clk_out, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n += int'(clk_out) + int'(tick);
    end
    chk("stop_lo_quiet", n, 0);
    cfg_write(2, 3);
    go();
    run_until_done(40, n, d);
    chk("burst_ticks", n, 3);
    chk("burst_done_at", d, 12);
    chk("burst_clk_low", clk_out, 0);
    chk("burst_busy_low", busy, 0);
    step();
    chk("burst_done_once", done, 0);
    cfg_write(4, 0);
    go();
    step(4);
    chk("live_rise", clk_out, 1);
    step();
    cif.cfg_valid = 1'b1; cif.cfg_div = 16'd1; cif.cfg_burst = 16'd0;
    step();
    cif.cfg_valid = 1'b0;
    chk("live_ready_low", cif.cfg_ready, 0);
    step();
    chk("live_ready_low2", cif.cfg_ready, 0);
    chk("live_still_high", clk_out, 1);
    step();
    chk("live_ready_back", cif.cfg_ready, 1);
    chk("live_fall", clk_out, 0);
    step();
    chk("live_fast_rise", clk_out, 1);
    chk("live_fast_tick", tick, 1);
    step();
    chk("live_fast_fall", clk_out, 0);
    step();
    chk("live_fast_rise2", clk_out, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("live_stop_clk", clk_out, 0);
    chk("live_stop_done", done, 1);
    cfg_write(0, 2);
    go();
    run_until_done(20, n, d);
    chk("clamp_ticks", n, 2);
    chk("clamp_done_at", d, 4);
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("collide_busy", busy, 0);
    chk("collide_done", done, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      n += int'(busy) + int'(clk_out);
    end
    chk("collide_quiet", n, 0);
    cfg_write(2, 0);
    go();
    step();
    cif.cfg_valid = 1'b1; cif.cfg_div = 16'd4; cif.cfg_burst = 16'd0;
    step();
    cif.cfg_valid = 1'b0;
    chk("tc_cfg_rise", clk_out, 1);
    chk("tc_cfg_ready", cif.cfg_ready, 0);
    step(2);
    chk("tc_cfg_fall_old", clk_out, 0);
    chk("tc_cfg_ready_back", cif.cfg_ready, 1);
    step(3);
    chk("tc_cfg_low_new", clk_out, 0);
    step();
    chk("tc_cfg_rise_new", clk_out, 1);
    chk("tc_cfg_tick_new", tick, 1);
    cif.cfg_valid = 1'b1; cif.cfg_div = 16'd1; cif.cfg_burst = 16'd0;
    step();
    cif.cfg_valid = 1'b0;
    chk("mid_pend", cif.cfg_ready, 0);
    chk("mid_high", clk_out, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_clk", clk_out, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cif.cfg_ready, 1);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_done", done, 0);
    go();
    step(3);
    chk("mid_rst_default_low", clk_out, 0);
    step();
    chk("mid_rst_default_rise", clk_out, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_pulse_scheduler.md
# clock_pulse_scheduler

Run-time controller for the clock-pulse conversion path. It sequences a programmable divider that derives a slow 50 %-duty pulse train (`clk_out`) and a one-cycle enable (`tick`) from the system clock. It provides start/stop control, glitch-free stop, burst mode, and a valid/ready port that reconfigures the divide ratio on a period boundary. It sits between the system clock and the slow-domain consumers (e.g. the 10 kHz enable derived from 50 MHz).

## Interface
Parameters:
- `DIV_W`, 16: width of the half-period divisor.
- `DEFAULT_DIV`, 2500: half-period in `clk_in` cycles after reset. 50 MHz / (2·2500) = 10 kHz.
- `BURST_W`, 16: width of the burst counter.

Ports:
- `clk_in`  in  1  sole clock. All logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level-sampled; begins running when in IDLE.
- `stop`  in  1  requests a glitch-free stop.
- `cfg_valid`  in  1  configuration offer.
- `cfg_ready`  out  1  configuration accepted when `cfg_valid & cfg_ready`.
- `cfg_div`  in  DIV_W  new half-period. 0 is clamped to 1.
- `cfg_burst`  in  BURST_W  rising edges per run. 0 means continuous.
- `clk_out`  out  1  divided pulse train, registered.
- `tick`  out  1  one-cycle pulse, coincident with each `clk_out` 0→1.
- `busy`  out  1  high in RUN and STOPPING.
- `done`  out  1  one-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, STOPPING.
- Reset values: state IDLE; `clk_out`, `tick`, `busy`, `done` = 0; `cfg_ready` = 1; active div = `DEFAULT_DIV`; burst = 0; counters = 0; no pending config.
- **IDLE**
  - `cfg_ready` = 1. An accepted config is written directly to the active registers.
  - `start & !stop` → RUN, counter cleared.
  - `start & stop` in the same cycle: stop wins, stay IDLE, no `done`.
- **RUN**
  - Counter increments each cycle. At `counter == div-1` it reaches terminal count (TC): `clk_out` toggles and the counter is cleared.
  - On a 0→1 toggle, `tick` pulses and the edge counter increments.
  - A config accepted in RUN goes to a shadow register. `cfg_ready` drops until the next TC, where the shadow is copied into the active registers.
  - A config accepted in the same cycle as a TC is applied at the following TC, not the current one.
  - `start` is ignored in RUN.
- **Stop**
  - `stop` while `clk_out`=0: → IDLE next cycle. The low phase is truncated, which produces no edge.
  - `stop` while `clk_out`=1: → STOPPING.
  - Burst end: when the edge count reaches a nonzero burst value, the block enters STOPPING.
- **STOPPING**
  - Continues counting until the falling TC (`clk_out` 1→0), then → IDLE.
  - `stop` and `start` are ignored in this state.
  - A pending shadow config is applied on entry to IDLE.
- `done` pulses for one cycle in the first IDLE cycle after RUN or STOPPING.
- `rst` in any state restores all reset values next edge. Pending config is discarded and `clk_out` is forced to 0.

## Timing
- `start` sampled at edge t → `busy`=1 from cycle t+1.
- First `clk_out` rise at cycle t+1+div. Period is 2·div cycles; high and low phases are div cycles each.
- div=1 gives a period of 2 cycles, with `tick` every 2 cycles.
- `tick` and `clk_out` change on the same edge. No combinational path from inputs to outputs.
- Config latency: applied at the first TC strictly after acceptance. The new half-period takes effect on the next phase.
- The edge counter saturates at the burst value. After a burst of N, exactly N `tick` pulses have been issued.

## Structure
- Package `clock_sched_pkg`: state enum (IDLE/RUN/STOPPING), the `DIV_W`/`BURST_W` defaults, and the clamp function (0→1).
- Sub-module `clock_div_core`: loadable half-period counter with TC output and `clk_out` toggle flop.
- The FSM, shadow config, and burst counter live in the top level.

## Test plan
- Reset: `DEFAULT_DIV`=4, hold `rst` 3 cycles → all outputs 0, `cfg_ready`=1. `start` at edge 0 → `clk_out` rises at cycle 5, period 8, `tick` every 8 cycles.
- Burst: IDLE config div=2, burst=3, then `start` → exactly 3 `tick`s. `clk_out` ends low, `done` one cycle, `busy` falls the same cycle `done` rises.
- Live reconfig: running div=4, offer div=1 mid-phase → `cfg_ready` low until the next TC. Subsequent phases are 1 cycle each, with no short pulse.
- Stop in high phase: assert `stop` 1 cycle after the rise with div=4 → `clk_out` stays high 4 cycles total, then low, then IDLE and `done`. Stop in low phase → IDLE the next cycle, `clk_out` stays 0.
- Clamp and collisions: `cfg_div`=0 → behaves as div=1. `start & stop` together in IDLE → no activity. Config accepted on the TC cycle → applied one TC later.
- Reset mid-run while `clk_out`=1 and a config is pending → all reset values next cycle; the pending config is not applied after a later `start`.
